latch_event_reader: RTL and testbench

//  Reader/clearing end of an asynchronous set/reset event latch. Synchronises
//  the latch output into CLK, emits a one-cycle EVENT per capture, then drives

---
 rtl/latch_event_reader_if.sv | 23 ++
 rtl/latch_event_reader.sv | 98 +++++++++
 tb/tb_latch_event_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/latch_event_reader_if.sv
// rtl/latch_event_reader_if.sv - latch-side and status signals of the event latch reader
interface latch_event_reader_if #(
   parameter int CNT_W = 8
);
   logic             latch_in;
   logic             enable;
   logic             err_clr;
   logic             latch_clr;
   logic             event_pulse;
   logic             busy;
   logic             error;
   logic [CNT_W-1:0] event_cnt;

   modport master (
      output latch_in, enable, err_clr,
      input  latch_clr, event_pulse, busy, error, event_cnt
   );

   modport slave (
      input  latch_in, enable, err_clr,
      output latch_clr, event_pulse, busy, error, event_cnt
   );
endinterface

// File: rtl/latch_event_reader.sv
// rtl/latch_event_reader.sv - synchronises an async set/reset latch, pulses EVENT, then clears the latch
module latch_event_reader #(
   parameter int SYNC_STAGES = 2,
   parameter int CLR_HOLD    = 2,
   parameter int TIMEOUT     = 15,
   parameter int CNT_W       = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   latch_event_reader_if.slave   bus
);
   localparam int HOLD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_FAULT} state_e;

   state_e                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [HOLD_W-1:0]      hold_q;
   logic                   clr_q;
   logic                   event_q;
   logic                   busy_q;
   logic                   error_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   sync;
   logic                   clear_done;
   logic                   timeout_hit;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.latch_in};
   assign sync   = sync_q[SYNC_STAGES-1];

   // A latch seen cleared after the minimum hold beats a coincident timeout.
   assign clear_done  = (state_q == ST_CLEAR) && (hold_q >= HOLD_W'(CLR_HOLD)) && !sync;
   assign timeout_hit = (state_q == ST_CLEAR) && !clear_done && (hold_q == HOLD_W'(TIMEOUT));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         sync_q  <= '0;
         hold_q  <= '0;
         clr_q   <= 1'b0;
         event_q <= 1'b0;
         busy_q  <= 1'b0;
         error_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         event_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sync && bus.enable) begin
                  state_q <= ST_CLEAR;
                  event_q <= 1'b1;
                  clr_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  hold_q  <= HOLD_W'(1);
               end
            end
            ST_CLEAR: begin
               if (clear_done) begin
                  state_q <= ST_IDLE;
                  clr_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (timeout_hit) begin
                  state_q <= ST_FAULT;
                  clr_q   <= 1'b0;
               end else begin
                  hold_q <= hold_q + HOLD_W'(1);
               end
            end
            ST_FAULT: begin
               // Wait for the stuck latch to drop before re-arming.
               if (!sync) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               clr_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
         if (timeout_hit) begin
            error_q <= 1'b1;
         end else if (bus.err_clr) begin
            error_q <= 1'b0;
         end
      end
   end

   assign bus.latch_clr   = clr_q;
   assign bus.event_pulse = event_q;
   assign bus.busy        = busy_q;
   assign bus.error       = error_q;
   assign bus.event_cnt   = cnt_q;
endmodule

// File: tb/tb_latch_event_reader.sv
// tb/tb_latch_event_reader.sv - self-checking bench for latch_event_reader
module tb_latch_event_reader;
   localparam int SYNC = 2;
   localparam int HOLD = 2;
   localparam int TMO  = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   latch_event_reader_if #(.CNT_W(8)) bus ();
   latch_event_reader_if #(.CNT_W(2)) bus2 ();

   latch_event_reader #(.CNT_W(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   latch_event_reader #(.CNT_W(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

   int checks = 0;
   int errors = 0;

   bit latch = 1'b0;
   bit stuck = 1'b0;

   bit hist[$];
   int mode;
   bit m_ev, m_clr, m_busy, m_err;
   int m_cnt, m_hold;

   typedef struct {
      bit rst, en, set, stuck;
      bit ev, clr, busy, err;
      int cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit en, input bit ec, input bit li);
      bit s;
      bit tmo;
      if (r) begin
         hist = {};
         for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
         mode = 0; m_ev = 0; m_clr = 0; m_busy = 0; m_err = 0; m_cnt = 0; m_hold = 0;
         return;
      end
      s = hist.pop_front();
      hist.push_back(li);
      tmo  = 1'b0;
      m_ev = 1'b0;
      case (mode)
         0: if (s && en) begin
               mode = 1; m_ev = 1; m_clr = 1; m_cnt++; m_hold = 1;
            end
         1: if (m_hold >= HOLD && !s) begin
               mode = 0; m_clr = 0;
            end else if (m_hold == TMO) begin
               mode = 2; m_clr = 0; tmo = 1;
            end else begin
               m_hold++;
            end
         default: if (!s) mode = 0;
      endcase
      m_busy = (mode != 0);
      if (tmo) m_err = 1;
      else if (ec) m_err = 0;
   endtask

   task automatic step(input bit r, input bit en, input bit ec, input bit st);
      rst = r;
      bus.enable = en;  bus2.enable = en;
      bus.err_clr = ec; bus2.err_clr = ec;
      latch = stuck ? 1'b1 : (m_clr ? 1'b0 : (latch | st));
      bus.latch_in = latch; bus2.latch_in = latch;
      @(posedge clk);
      model_edge(r, en, ec, latch);
      #1;
      chk("model_event", bus.event_pulse, m_ev);
      chk("model_clr", bus.latch_clr, m_clr);
      chk("model_busy", bus.busy, m_busy);
      chk("model_error", bus.error, m_err);
      chk("model_cnt", bus.event_cnt, m_cnt % 256);
      chk("model_cnt2", bus2.event_cnt, m_cnt % 4);
   endtask

   task automatic add(input bit r, en, s, st, ev, clr, busy, err, input int cnt);
      vec_t v;
      v.rst = r; v.en = en; v.set = s; v.stuck = st;
      v.ev = ev; v.clr = clr; v.busy = busy; v.err = err; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   initial begin
      int n, nev, nclr;
      int wrap_exp[5];
      wrap_exp = '{1, 2, 3, 0, 1};
      model_edge(1'b1, 1'b0, 1'b0, 1'b0);
      bus.enable = 0; bus.err_clr = 0; bus.latch_in = 0;
      bus2.enable = 0; bus2.err_clr = 0; bus2.latch_in = 0;

      // reset with latch held set, then capture of the leftover set after release
      repeat (3) add(1, 1, 0, 1, 0, 0, 0, 0, 0);
      repeat (2) add(0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 1, 1, 1, 0, 1);
      repeat (2) add(0, 1, 0, 0, 0, 1, 1, 0, 1);
      add(0, 1, 0, 0, 0, 0, 0, 0, 1);
      // single SET pulse: EVENT on the third edge
      add(0, 1, 1, 0, 0, 0, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 0, 0, 1);
      add(0, 1, 0, 0, 1, 1, 1, 0, 2);
      repeat (2) add(0, 1, 0, 0, 0, 1, 1, 0, 2);
      add(0, 1, 0, 0, 0, 0, 0, 0, 2);
      // enable low with pending latch, then enable, then set absorbed during clear
      add(0, 0, 1, 0, 0, 0, 0, 0, 2);
      repeat (9) add(0, 0, 0, 0, 0, 0, 0, 0, 2);
      add(0, 1, 0, 0, 1, 1, 1, 0, 3);
      add(0, 1, 1, 0, 0, 1, 1, 0, 3);
      add(0, 1, 0, 0, 0, 1, 1, 0, 3);
      repeat (3) add(0, 1, 0, 0, 0, 0, 0, 0, 3);

      for (int i = 0; i < tbl.size(); i++) begin
         stuck = tbl[i].stuck;
         step(tbl[i].rst, tbl[i].en, 1'b0, tbl[i].set);
         chk("tbl_event", bus.event_pulse, tbl[i].ev);
         chk("tbl_clr", bus.latch_clr, tbl[i].clr);
         chk("tbl_busy", bus.busy, tbl[i].busy);
         chk("tbl_error", bus.error, tbl[i].err);
         chk("tbl_cnt", bus.event_cnt, tbl[i].cnt);
      end

      // stuck latch: 15 cycles of clear, fault, release, error clear
      stuck = 1'b1;
      nev = 0; nclr = 0;
      repeat (40) begin
         step(0, 1, 0, 0);
         nev  += int'(bus.event_pulse);
         nclr += int'(bus.latch_clr);
      end
      chk("stuck_clr_cycles", nclr, TMO);
      chk("stuck_events", nev, 1);
      chk("stuck_error", bus.error, 1);
      chk("stuck_busy", bus.busy, 1);
      stuck = 1'b0;
      latch = 1'b0;
      n = 0;
      while (bus.busy && n < 10) begin step(0, 1, 0, 0); n++; end
      chk("fault_exit_busy", bus.busy, 0);
      chk("fault_error_kept", bus.error, 1);
      step(0, 1, 1, 0);
      chk("err_clr", bus.error, 0);

      // reset during clear with the latch still set
      step(0, 1, 0, 1);
      n = 0;
      while (!bus.latch_clr && n < 10) begin step(0, 1, 0, 0); n++; end
      chk("midclr_reached", bus.latch_clr, 1);
      stuck = 1'b1;
      step(1, 1, 0, 0);
      chk("midclr_rst_clr", bus.latch_clr, 0);
      chk("midclr_rst_busy", bus.busy, 0);
      chk("midclr_rst_cnt", bus.event_cnt, 0);
      stuck = 1'b0;
      n = 0;
      step(0, 1, 0, 0);
      while (!bus.event_pulse && n < 10) begin step(0, 1, 0, 0); n++; end
      chk("recapture_event", bus.event_pulse, 1);
      chk("recapture_cnt", bus.event_cnt, 1);
      repeat (6) step(0, 1, 0, 0);

      // counter wrap on the 2-bit instance
      step(1, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(0, 1, 0, 1);
         n = 0;
         while (!bus2.event_pulse && n < 10) begin step(0, 1, 0, 0); n++; end
         chk("wrap_event", bus2.event_pulse, 1);
         chk("wrap_cnt", bus2.event_cnt, wrap_exp[k]);
         repeat (6) step(0, 1, 0, 0);
      end

      // randomized traffic against the model
      repeat (3000) begin
         bit r, en, ec, s;
         if ($urandom_range(0, 299) == 0) begin
            stuck = !stuck;
            if (!stuck) latch = 1'b0;
         end
         r  = ($urandom_range(0, 499) == 0);
         en = ($urandom_range(0, 7) != 0);
         ec = ($urandom_range(0, 15) == 0);
         s  = ($urandom_range(0, 5) == 0);
         step(r, en, ec, s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
